// File: rtl/frame_draw_sequencer_pkg.sv
// ============================================================================
// Module   : frame_draw_sequencer_pkg
// Brief    : Shared FSM encoding, default widths and helpers for the draw engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_draw_sequencer_pkg;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam int DEF_NUM_LAYERS   = 4;
    localparam int DEF_X_WIDTH      = 9;
    localparam int DEF_Y_WIDTH      = 8;
    localparam int DEF_COLOUR_WIDTH = 6;

    localparam logic [7:0] OVERRUN_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_DRAW = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } fds_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == OVERRUN_MAX) ? value : value + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_draw_sequencer_if.sv
// ============================================================================
// Module   : frame_draw_sequencer_if
// Brief    : Layer handshake, pixel buses and VGA-side outputs of the draw engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_draw_sequencer_if #(
    parameter int NUM_LAYERS   = 4,
    parameter int X_WIDTH      = 9,
    parameter int Y_WIDTH      = 8,
    parameter int COLOUR_WIDTH = 6
);
    logic                             run;
    logic [NUM_LAYERS-1:0]            layer_enable;
    logic [NUM_LAYERS-1:0]            layer_key_en;
    logic [NUM_LAYERS-1:0]            layer_draw;
    logic [NUM_LAYERS-1:0]            layer_done;
    logic [NUM_LAYERS*X_WIDTH-1:0]    layer_x;
    logic [NUM_LAYERS*Y_WIDTH-1:0]    layer_y;
    logic [NUM_LAYERS*COLOUR_WIDTH-1:0] layer_colour;
    logic [NUM_LAYERS-1:0]            layer_write;
    logic [X_WIDTH-1:0]               x_position;
    logic [Y_WIDTH-1:0]               y_position;
    logic [COLOUR_WIDTH-1:0]          colour;
    logic                             VGA_enable;
    logic                             frame_busy;
    logic                             frame_done;
    logic [7:0]                       overrun_count;

    modport master (
        output run, layer_enable, layer_key_en, layer_done,
        output layer_x, layer_y, layer_colour, layer_write,
        input  layer_draw, x_position, y_position, colour,
        input  VGA_enable, frame_busy, frame_done, overrun_count
    );

    modport slave (
        input  run, layer_enable, layer_key_en, layer_done,
        input  layer_x, layer_y, layer_colour, layer_write,
        output layer_draw, x_position, y_position, colour,
        output VGA_enable, frame_busy, frame_done, overrun_count
    );
endinterface

`default_nettype wire

// File: rtl/frame_draw_sequencer_frame_timer.sv
// ============================================================================
// Module   : frame_draw_sequencer_frame_timer
// Brief    : Free-running frame counter gated by run; ticks on the last count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_draw_sequencer_frame_timer #(
    parameter int FRAME_COUNT = 1666666,
    parameter int CNT_WIDTH   = 24
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic run_i,
    output logic      tick_o
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FRAME_COUNT - 1);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // A stopped timer restarts from zero so the first tick is a full frame away.
    always_comb begin
        count_d = count_q;
        if (!run_i) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = run_i && (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/frame_draw_sequencer.sv
// ============================================================================
// Module   : frame_draw_sequencer
// Brief    : Walks enabled draw layers per frame and forwards their pixels to VGA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_draw_sequencer #(
    parameter int NUM_LAYERS   = 4,
    parameter int X_WIDTH      = 9,
    parameter int Y_WIDTH      = 8,
    parameter int COLOUR_WIDTH = 6,
    parameter int FRAME_COUNT  = 1666666,
    parameter int CNT_WIDTH    = 24,
    parameter logic [COLOUR_WIDTH-1:0] KEY_COLOUR = '0
) (
    input  wire logic clock,
    input  wire logic reset,
    frame_draw_sequencer_if.slave bus
);
    import frame_draw_sequencer_pkg::*;

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [NUM_LAYERS-1:0] LAYER_ONE = NUM_LAYERS'(1);

    fds_state_e              state_q, state_d;
    logic [IDX_W-1:0]        cur_q, cur_d;
    logic [NUM_LAYERS-1:0]   en_mask_q, en_mask_d;
    logic [NUM_LAYERS-1:0]   key_mask_q, key_mask_d;
    logic                    pending_q, pending_d;
    logic [7:0]              overrun_q, overrun_d;
    logic [X_WIDTH-1:0]      x_q, x_d;
    logic [Y_WIDTH-1:0]      y_q, y_d;
    logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
    logic                    vga_en_q, vga_en_d;

    logic                    tick;
    logic                    start;
    logic [IDX_W-1:0]        first_idx, next_idx;
    logic                    first_found, next_found;
    logic                    cur_done, cur_write, cur_key;
    logic [X_WIDTH-1:0]      cur_x;
    logic [Y_WIDTH-1:0]      cur_y;
    logic [COLOUR_WIDTH-1:0] cur_colour;

    frame_draw_sequencer_frame_timer #(
        .FRAME_COUNT (FRAME_COUNT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_frame_timer (
        .clock  (clock),
        .reset  (reset),
        .run_i  (bus.run),
        .tick_o (tick)
    );

    // Lowest enabled layer of the live mask (frame start) and next enabled above cur.
    always_comb begin
        first_idx   = '0;
        first_found = 1'b0;
        next_idx    = '0;
        next_found  = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (bus.layer_enable[i]) begin
                first_idx   = IDX_W'(i);
                first_found = 1'b1;
            end
            if (en_mask_q[i] && (i > int'(cur_q))) begin
                next_idx   = IDX_W'(i);
                next_found = 1'b1;
            end
        end
    end

    assign cur_done   = bus.layer_done[cur_q];
    assign cur_write  = bus.layer_write[cur_q];
    assign cur_key    = key_mask_q[cur_q];
    assign cur_x      = bus.layer_x[int'(cur_q) * X_WIDTH +: X_WIDTH];
    assign cur_y      = bus.layer_y[int'(cur_q) * Y_WIDTH +: Y_WIDTH];
    assign cur_colour = bus.layer_colour[int'(cur_q) * COLOUR_WIDTH +: COLOUR_WIDTH];

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        en_mask_d  = en_mask_q;
        key_mask_d = key_mask_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        start      = 1'b0;

        if (tick && (state_q != ST_WAIT)) begin
            overrun_d = sat_inc8(overrun_q);
            pending_d = ON;
        end

        case (state_q)
            ST_WAIT: start = tick | pending_q;
            ST_DRAW: if (cur_done) state_d = ST_GAP;
            ST_GAP: begin
                if (next_found) begin
                    state_d = ST_DRAW;
                    cur_d   = next_idx;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (pending_q || tick) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        // Starting a frame consumes any pending tick, including one that just arrived in DONE.
        if (start) begin
            pending_d  = OFF;
            en_mask_d  = bus.layer_enable;
            key_mask_d = bus.layer_key_en;
            if (first_found) begin
                state_d = ST_DRAW;
                cur_d   = first_idx;
            end else begin
                state_d = ST_DONE;
            end
        end
    end

    always_comb begin
        x_d      = '0;
        y_d      = '0;
        colour_d = '0;
        vga_en_d = OFF;
        if (state_q == ST_DRAW) begin
            x_d      = cur_x;
            y_d      = cur_y;
            colour_d = cur_colour;
            vga_en_d = cur_write & ~cur_done & ~(cur_key & (cur_colour == KEY_COLOUR));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_WAIT;
            cur_q      <= '0;
            en_mask_q  <= '0;
            key_mask_q <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            vga_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            en_mask_q  <= en_mask_d;
            key_mask_q <= key_mask_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            vga_en_q   <= vga_en_d;
        end
    end

    assign bus.layer_draw    = (state_q == ST_DRAW) ? (LAYER_ONE << cur_q) : '0;
    assign bus.frame_busy    = (state_q == ST_DRAW) || (state_q == ST_GAP);
    assign bus.frame_done    = (state_q == ST_DONE);
    assign bus.x_position    = x_q;
    assign bus.y_position    = y_q;
    assign bus.colour        = colour_q;
    assign bus.VGA_enable    = vga_en_q;
    assign bus.overrun_count = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_draw_sequencer.sv
// ============================================================================
// Module   : tb_frame_draw_sequencer
// Brief    : Directed self-checking bench for frame_draw_sequencer (4 layers, 16-clock frames).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_draw_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   dly [4];
    int   cnt [4];

    frame_draw_sequencer_if #(
        .NUM_LAYERS(4), .X_WIDTH(9), .Y_WIDTH(8), .COLOUR_WIDTH(6)
    ) bus ();

    frame_draw_sequencer #(
        .NUM_LAYERS(4), .X_WIDTH(9), .Y_WIDTH(8), .COLOUR_WIDTH(6),
        .FRAME_COUNT(16), .CNT_WIDTH(8), .KEY_COLOUR(6'b000000)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Layer stand-in: done rises dly[i] cycles after that layer's draw rises, drops with draw.
    task automatic respond();
        for (int i = 0; i < 4; i++) begin
            if (bus.layer_draw[i]) begin
                cnt[i]++;
                bus.layer_done[i] = (cnt[i] >= dly[i] + 1);
            end else begin
                cnt[i] = 0;
                bus.layer_done[i] = 1'b0;
            end
        end
    endtask

    task automatic set_pix(input int idx, input logic [8:0] x, input logic [7:0] y,
                           input logic [5:0] col);
        bus.layer_write[idx]       = 1'b1;
        bus.layer_x[idx*9 +: 9]    = x;
        bus.layer_y[idx*8 +: 8]    = y;
        bus.layer_colour[idx*6 +: 6] = col;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.run = 1'b0;
        bus.layer_enable = '0;
        bus.layer_key_en = '0;
        bus.layer_done = '0;
        bus.layer_write = '0;
        bus.layer_x = '0;
        bus.layer_y = '0;
        bus.layer_colour = '0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            dly[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (bus.layer_draw !== 4'b0000) begin failures++; $display("FAIL reset_draw got=%b want=0000", bus.layer_draw); end
        checks++; if (bus.x_position !== 9'd0) begin failures++; $display("FAIL reset_x got=%0d want=0", bus.x_position); end
        checks++; if (bus.y_position !== 8'd0) begin failures++; $display("FAIL reset_y got=%0d want=0", bus.y_position); end
        checks++; if (bus.colour !== 6'd0) begin failures++; $display("FAIL reset_colour got=%0d want=0", bus.colour); end
        checks++; if (bus.VGA_enable !== 1'b0) begin failures++; $display("FAIL reset_vga_en got=%b want=0", bus.VGA_enable); end
        checks++; if (bus.frame_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.frame_busy); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.frame_done); end
        checks++; if (bus.overrun_count !== 8'd0) begin failures++; $display("FAIL reset_overrun got=%0d want=0", bus.overrun_count); end
    endtask

    // Mask 1011, 3-cycle layers: tick at 15 -> draw0 16..19, gap 20, draw1 21..24, gap 25, draw3 26..29, gap 30, done 31.
    task automatic test_draw_order();
        logic [3:0] exp_draw;
        apply_reset();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            exp_draw = (c >= 16 && c <= 19) ? 4'b0001 :
                       (c >= 21 && c <= 24) ? 4'b0010 :
                       (c >= 26 && c <= 29) ? 4'b1000 : 4'b0000;
            checks++; if (bus.layer_draw !== exp_draw) begin failures++; $display("FAIL order_draw c=%0d got=%b want=%b", c, bus.layer_draw, exp_draw); end
            checks++; if (bus.frame_busy !== (c >= 16 && c <= 30)) begin failures++; $display("FAIL order_busy c=%0d got=%b", c, bus.frame_busy); end
            checks++; if (bus.frame_done !== (c == 31)) begin failures++; $display("FAIL order_done c=%0d got=%b", c, bus.frame_done); end
            respond();
            if (c == 0) begin
                bus.run = 1'b1;
                bus.layer_enable = 4'b1011;
                for (int i = 0; i < 4; i++) dly[i] = 3;
            end
            if (c == 16) bus.run = 1'b0;
            if (c == 18) bus.layer_enable = 4'b1111;
        end
        checks++; if (bus.overrun_count !== 8'd0) begin failures++; $display("FAIL order_overrun got=%0d want=0", bus.overrun_count); end
    endtask

    // Layer 0 unkeyed (1 cycle), layer 1 keyed (3 cycles): draw0 16..17, gap 18, draw1 19..22, gap 23, done 24.
    task automatic test_colour_key();
        apply_reset();
        for (int c = 0; c <= 26; c++) begin
            @(negedge clk);
            case (c)
                17: begin
                    checks++; if (bus.VGA_enable !== 1'b1) begin failures++; $display("FAIL key_unkeyed_en c=17 got=%b want=1", bus.VGA_enable); end
                    checks++; if (bus.colour !== 6'd0 || bus.x_position !== 9'd3 || bus.y_position !== 8'd4) begin failures++; $display("FAIL key_unkeyed_pix col=%0d x=%0d y=%0d want 0/3/4", bus.colour, bus.x_position, bus.y_position); end
                end
                18, 20, 22: begin
                    checks++; if (bus.VGA_enable !== 1'b0) begin failures++; $display("FAIL key_en_low c=%0d got=%b want=0", c, bus.VGA_enable); end
                end
                21: begin
                    checks++; if (bus.VGA_enable !== 1'b1) begin failures++; $display("FAIL key_en_high c=21 got=%b want=1", bus.VGA_enable); end
                    checks++; if (bus.colour !== 6'd5 || bus.x_position !== 9'd11 || bus.y_position !== 8'd21) begin failures++; $display("FAIL key_pix col=%0d x=%0d y=%0d want 5/11/21", bus.colour, bus.x_position, bus.y_position); end
                end
                23: begin
                    checks++; if (bus.VGA_enable !== 1'b0) begin failures++; $display("FAIL key_done_write c=23 got=%b want=0", bus.VGA_enable); end
                    checks++; if (bus.colour !== 6'd7 || bus.x_position !== 9'd40) begin failures++; $display("FAIL key_done_pix col=%0d x=%0d want 7/40", bus.colour, bus.x_position); end
                end
                24: begin
                    checks++; if (bus.colour !== 6'd0 || bus.x_position !== 9'd0 || bus.y_position !== 8'd0) begin failures++; $display("FAIL key_idle_pix col=%0d x=%0d y=%0d want 0", bus.colour, bus.x_position, bus.y_position); end
                    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL key_frame_done got=%b want=1", bus.frame_done); end
                end
                default: ;
            endcase
            respond();
            bus.layer_write = '0;
            case (c)
                0: begin
                    bus.run = 1'b1;
                    bus.layer_enable = 4'b0011;
                    bus.layer_key_en = 4'b0010;
                    dly[0] = 1;
                    dly[1] = 3;
                end
                16: begin bus.run = 1'b0; set_pix(0, 9'd3, 8'd4, 6'd0); end
                19: set_pix(1, 9'd10, 8'd20, 6'd0);
                20: begin set_pix(1, 9'd11, 8'd21, 6'd5); bus.layer_key_en = 4'b0000; end
                21: set_pix(1, 9'd12, 8'd22, 6'd0);
                22: set_pix(1, 9'd40, 8'd50, 6'd7);
                default: ;
            endcase
        end
    endtask

    // 41-cycle layer: ticks 31 (pending) and 47 (dropped) overrun; done 58, second frame 59..61, done 63.
    task automatic test_overrun();
        logic [7:0] exp_ov;
        apply_reset();
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            exp_ov = (c < 32) ? 8'd0 : (c < 48) ? 8'd1 : 8'd2;
            checks++; if (bus.overrun_count !== exp_ov) begin failures++; $display("FAIL ovr_count c=%0d got=%0d want=%0d", c, bus.overrun_count, exp_ov); end
            checks++; if (bus.layer_draw !== (((c >= 16 && c <= 56) || (c >= 59 && c <= 61)) ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL ovr_draw c=%0d got=%b", c, bus.layer_draw); end
            checks++; if (bus.frame_done !== (c == 58 || c == 63)) begin failures++; $display("FAIL ovr_done c=%0d got=%b", c, bus.frame_done); end
            checks++; if (bus.frame_busy !== ((c >= 16 && c <= 57) || (c >= 59 && c <= 62))) begin failures++; $display("FAIL ovr_busy c=%0d got=%b", c, bus.frame_busy); end
            respond();
            if (c == 0) begin bus.run = 1'b1; bus.layer_enable = 4'b0001; dly[0] = 40; end
            if (c == 58) dly[0] = 2;
            if (c == 59) bus.run = 1'b0;
        end
    endtask

    // 14-cycle layer ends with DONE at 31, which coincides with the next tick.
    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c <= 52; c++) begin
            @(negedge clk);
            checks++; if (bus.layer_draw !== (((c >= 16 && c <= 29) || (c >= 32 && c <= 45)) ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL b2b_draw c=%0d got=%b", c, bus.layer_draw); end
            checks++; if (bus.frame_done !== (c == 31 || c == 47)) begin failures++; $display("FAIL b2b_done c=%0d got=%b", c, bus.frame_done); end
            checks++; if (bus.overrun_count !== ((c >= 32) ? 8'd1 : 8'd0)) begin failures++; $display("FAIL b2b_overrun c=%0d got=%0d", c, bus.overrun_count); end
            respond();
            if (c == 0) begin bus.run = 1'b1; bus.layer_enable = 4'b0001; dly[0] = 13; end
            if (c == 32) bus.run = 1'b0;
        end
    endtask

    task automatic test_empty_mask();
        apply_reset();
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            checks++; if (bus.layer_draw !== 4'b0000) begin failures++; $display("FAIL empty_draw c=%0d got=%b want=0000", c, bus.layer_draw); end
            checks++; if (bus.frame_busy !== 1'b0) begin failures++; $display("FAIL empty_busy c=%0d got=%b want=0", c, bus.frame_busy); end
            checks++; if (bus.frame_done !== (c == 16)) begin failures++; $display("FAIL empty_done c=%0d got=%b", c, bus.frame_done); end
            respond();
            if (c == 0) begin bus.run = 1'b1; bus.layer_enable = 4'b0000; end
            if (c == 16) bus.run = 1'b0;
        end
    endtask

    // Reset during layer 2 at cycle 20; next tick at 36 restarts from layer 0.
    task automatic test_reset_mid_frame();
        apply_reset();
        for (int c = 0; c <= 46; c++) begin
            @(negedge clk);
            case (c)
                20: begin
                    checks++; if (bus.layer_draw !== 4'b0100 || bus.VGA_enable !== 1'b1 || bus.colour !== 6'd9) begin failures++; $display("FAIL rst_pre draw=%b en=%b col=%0d want 0100/1/9", bus.layer_draw, bus.VGA_enable, bus.colour); end
                end
                21: begin
                    checks++; if (bus.layer_draw !== 4'b0000 || bus.frame_busy !== 1'b0 || bus.frame_done !== 1'b0) begin failures++; $display("FAIL rst_ctrl draw=%b busy=%b done=%b want 0", bus.layer_draw, bus.frame_busy, bus.frame_done); end
                    checks++; if (bus.VGA_enable !== 1'b0 || bus.colour !== 6'd0 || bus.x_position !== 9'd0 || bus.y_position !== 8'd0) begin failures++; $display("FAIL rst_pix en=%b col=%0d x=%0d y=%0d want 0", bus.VGA_enable, bus.colour, bus.x_position, bus.y_position); end
                end
                36: begin
                    checks++; if (bus.layer_draw !== 4'b0000) begin failures++; $display("FAIL rst_early got=%b want=0000", bus.layer_draw); end
                end
                37: begin
                    checks++; if (bus.layer_draw !== 4'b0001) begin failures++; $display("FAIL rst_restart got=%b want=0001", bus.layer_draw); end
                end
                40: begin
                    checks++; if (bus.layer_draw !== 4'b0100) begin failures++; $display("FAIL rst_second got=%b want=0100", bus.layer_draw); end
                end
                41: begin
                    checks++; if (bus.VGA_enable !== 1'b1 || bus.x_position !== 9'd33 || bus.y_position !== 8'd44) begin failures++; $display("FAIL rst_write en=%b x=%0d y=%0d want 1/33/44", bus.VGA_enable, bus.x_position, bus.y_position); end
                end
                43: begin
                    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL rst_done got=%b want=1", bus.frame_done); end
                end
                default: ;
            endcase
            respond();
            bus.layer_write = '0;
            set_pix(2, 9'd33, 8'd44, 6'd9);
            if (c == 0) begin bus.run = 1'b1; bus.layer_enable = 4'b0100; dly[2] = 20; end
            if (c == 20) begin rst = 1'b1; bus.layer_enable = 4'b0101; dly[0] = 1; dly[2] = 1; end
            if (c == 21) rst = 1'b0;
            if (c == 37) bus.run = 1'b0;
        end
    endtask

    // Short run burst then 35 idle cycles; run from 50 gives the tick at 65.
    task automatic test_run_gating();
        apply_reset();
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            checks++; if (bus.layer_draw !== ((c == 66) ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL run_draw c=%0d got=%b", c, bus.layer_draw); end
            checks++; if (bus.frame_done !== (c == 68)) begin failures++; $display("FAIL run_done c=%0d got=%b", c, bus.frame_done); end
            respond();
            if (c == 0) begin bus.layer_enable = 4'b0001; dly[0] = 0; end
            if (c == 5) bus.run = 1'b1;
            if (c == 15) bus.run = 1'b0;
            if (c == 50) bus.run = 1'b1;
            if (c == 67) bus.run = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        test_reset();
        test_draw_order();
        test_colour_key();
        test_overrun();
        test_back_to_back();
        test_empty_mask();
        test_reset_mid_frame();
        test_run_gating();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
